// File: rtl/i2c_master_byte_ctrl_pkg.sv
// Shared command codes and byte-sequencer state encoding for the I2C master.
// The bit controller uses the same command codes.
package i2c_master_byte_ctrl_pkg;

  typedef logic [3:0] i2c_cmd_t;

  localparam i2c_cmd_t I2C_CMD_NOP   = 4'b0000;
  localparam i2c_cmd_t I2C_CMD_START = 4'b0001;
  localparam i2c_cmd_t I2C_CMD_STOP  = 4'b0010;
  localparam i2c_cmd_t I2C_CMD_WRITE = 4'b0100;
  localparam i2c_cmd_t I2C_CMD_READ  = 4'b1000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

endpackage

// File: rtl/i2c_master_byte_ctrl_if.sv
// Host request / bit-controller bus seen by the byte sequencer.
// The slave modport is the sequencer; the master modport drives it.
interface i2c_master_byte_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic          Start;
  logic          Stop;
  logic          Read;
  logic          Write;
  logic          Ack_in;
  logic [DW-1:0] Din;
  logic          Cmd_ack;
  logic          Ack_out;
  logic [DW-1:0] Dout;
  logic          I2C_al;
  logic [3:0]    Bit_cmd;
  logic          Bit_ack;
  logic          Bit_txd;
  logic          Bit_rxd;
  logic          Bit_al;

  modport slave (
    input  Start, Stop, Read, Write, Ack_in, Din, Bit_ack, Bit_rxd, Bit_al,
    output Cmd_ack, Ack_out, Dout, I2C_al, Bit_cmd, Bit_txd
  );

  modport master (
    output Start, Stop, Read, Write, Ack_in, Din, Bit_ack, Bit_rxd, Bit_al,
    input  Cmd_ack, Ack_out, Dout, I2C_al, Bit_cmd, Bit_txd
  );
endinterface

// File: rtl/i2c_byte_shreg.sv
// Loadable MSB-first shift register with a down-counter of remaining bits.
// cnt_done is high while the last bit of the byte is in flight.
module i2c_byte_shreg #(
  parameter  int unsigned DW = 8,
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic          shift,
  input  logic [DW-1:0] din,
  input  logic          sin,
  output logic [DW-1:0] sr,
  output logic          cnt_done
);

  logic [DW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (ld) begin
      sr_d  = din;
      cnt_d = CW'(DW - 1);
    end else if (shift) begin
      sr_d  = {sr_q[DW-2:0], sin};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr       = sr_q;
  assign cnt_done = (cnt_q == '0);

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C sequencer: turns one host request into START / data bits / ACK / STOP
// commands for the bit controller, aborting on arbitration loss.
module i2c_master_byte_ctrl #(
  parameter int unsigned DW = 8
) (
  input logic                  Clk,
  input logic                  Rst_n,
  i2c_master_byte_ctrl_if.slave bus
);
  import i2c_master_byte_ctrl_pkg::*;

  logic [2:0]    state_q, state_d;
  i2c_cmd_t      bit_cmd_q, bit_cmd_d;
  logic          txd_q, txd_d;
  logic          cmd_ack_q, cmd_ack_d;
  logic          ack_out_q, ack_out_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          al_q, al_d;

  logic          ld, shift, sin, cnt_done, go;
  logic [DW-1:0] sr;

  i2c_byte_shreg #(.DW(DW)) u_shreg (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .ld       (ld),
    .shift    (shift),
    .din      (bus.Din),
    .sin      (sin),
    .sr       (sr),
    .cnt_done (cnt_done)
  );

  assign go = (bus.Read | bus.Write | bus.Stop) & ~cmd_ack_q;

  // Command and txd are registered together with the state, so each new
  // command appears on the bus in the same cycle the state takes effect.
  always_comb begin
    state_d   = state_q;
    bit_cmd_d = bit_cmd_q;
    txd_d     = txd_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;
    dout_d    = dout_q;
    al_d      = bus.Bit_al;
    ld        = 1'b0;
    shift     = 1'b0;
    sin       = 1'b0;

    if (bus.Bit_al) begin
      state_d   = ST_IDLE;
      bit_cmd_d = I2C_CMD_NOP;
      txd_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            ld    = 1'b1;
            txd_d = 1'b0;
            if (bus.Start) begin
              state_d   = ST_START;
              bit_cmd_d = I2C_CMD_START;
            end else if (bus.Read) begin
              state_d   = ST_READ;
              bit_cmd_d = I2C_CMD_READ;
            end else if (bus.Write) begin
              state_d   = ST_WRITE;
              bit_cmd_d = I2C_CMD_WRITE;
              txd_d     = bus.Din[DW-1];
            end else begin
              state_d   = ST_STOP;
              bit_cmd_d = I2C_CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (bus.Bit_ack) begin
            if (bus.Read) begin
              state_d   = ST_READ;
              bit_cmd_d = I2C_CMD_READ;
              txd_d     = 1'b0;
            end else begin
              state_d   = ST_WRITE;
              bit_cmd_d = I2C_CMD_WRITE;
              txd_d     = sr[DW-1];
            end
          end
        end

        ST_WRITE: begin
          if (bus.Bit_ack) begin
            shift = 1'b1;
            if (cnt_done) begin
              state_d   = ST_ACK;
              bit_cmd_d = I2C_CMD_READ;
              txd_d     = 1'b0;
            end else begin
              txd_d = sr[DW-2];
            end
          end
        end

        ST_READ: begin
          if (bus.Bit_ack) begin
            shift = 1'b1;
            sin   = bus.Bit_rxd;
            if (cnt_done) begin
              state_d   = ST_ACK;
              bit_cmd_d = I2C_CMD_WRITE;
              txd_d     = bus.Ack_in;
            end
          end
        end

        ST_ACK: begin
          if (bus.Bit_ack) begin
            ack_out_d = bus.Bit_rxd;
            dout_d    = sr;
            txd_d     = 1'b0;
            if (bus.Stop) begin
              state_d   = ST_STOP;
              bit_cmd_d = I2C_CMD_STOP;
            end else begin
              state_d   = ST_IDLE;
              bit_cmd_d = I2C_CMD_NOP;
              cmd_ack_d = 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (bus.Bit_ack) begin
            state_d   = ST_IDLE;
            bit_cmd_d = I2C_CMD_NOP;
            txd_d     = 1'b0;
            cmd_ack_d = 1'b1;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          bit_cmd_d = I2C_CMD_NOP;
          txd_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      bit_cmd_q <= I2C_CMD_NOP;
      txd_q     <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      dout_q    <= '0;
      al_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cmd_q <= bit_cmd_d;
      txd_q     <= txd_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      dout_q    <= dout_d;
      al_q      <= al_d;
    end
  end

  assign bus.Bit_cmd = bit_cmd_q;
  assign bus.Bit_txd = txd_q;
  assign bus.Cmd_ack = cmd_ack_q;
  assign bus.Ack_out = ack_out_q;
  assign bus.Dout    = dout_q;
  assign bus.I2C_al  = al_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed bench for the byte sequencer: the initial block plays both host and bit controller.
module tb_i2c_master_byte_ctrl;
  import i2c_master_byte_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  i2c_master_byte_ctrl_if #(.DW(8)) bus ();

  i2c_master_byte_ctrl #(.DW(8)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Checks the command on the bus, then acknowledges it with the given rxd.
  task automatic bit_step(input string tag, input logic [3:0] exp_cmd,
                          input logic chk_txd, input logic exp_txd, input logic rxd);
    check({tag, "_cmd"}, 32'(bus.Bit_cmd), 32'(exp_cmd));
    if (chk_txd) check({tag, "_txd"}, 32'(bus.Bit_txd), 32'(exp_txd));
    check({tag, "_noack"}, 32'(bus.Cmd_ack), 32'd0);
    bus.Bit_ack = 1'b1;
    bus.Bit_rxd = rxd;
    @(negedge clk);
    bus.Bit_ack = 1'b0;
    bus.Bit_rxd = 1'b0;
  endtask

  task automatic finish_req(input string tag);
    check({tag, "_cmdack"}, 32'(bus.Cmd_ack), 32'd1);
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    bus.Read  = 1'b0;
    bus.Write = 1'b0;
    @(negedge clk);
    check({tag, "_cmdack_pulse"}, 32'(bus.Cmd_ack), 32'd0);
    check({tag, "_nop"}, 32'(bus.Bit_cmd), 32'(I2C_CMD_NOP));
  endtask

  initial begin
    logic [7:0] din;
    logic [7:0] rx;
    n_checks = 0;
    n_pass   = 0;
    rst_n       = 1'b0;
    bus.Start   = 1'b0;
    bus.Stop    = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.Ack_in  = 1'b0;
    bus.Din     = '0;
    bus.Bit_ack = 1'b0;
    bus.Bit_rxd = 1'b0;
    bus.Bit_al  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd",    32'(bus.Bit_cmd), 32'(I2C_CMD_NOP));
    check("rst_txd",    32'(bus.Bit_txd), 32'd0);
    check("rst_cmdack", 32'(bus.Cmd_ack), 32'd0);
    check("rst_ackout", 32'(bus.Ack_out), 32'd0);
    check("rst_dout",   32'(bus.Dout),    32'd0);
    check("rst_al",     32'(bus.I2C_al),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: START + write 0xA5, slave ACKs
    din = 8'hA5;
    bus.Start = 1'b1; bus.Write = 1'b1; bus.Din = din;
    @(negedge clk);
    bit_step("t1_start", I2C_CMD_START, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      bit_step($sformatf("t1_b%0d", i), I2C_CMD_WRITE, 1'b1, din[7-i], 1'b0);
    bit_step("t1_ack", I2C_CMD_READ, 1'b0, 1'b0, 1'b0);
    check("t1_ackout", 32'(bus.Ack_out), 32'd0);
    finish_req("t1");

    // 2: read 0x6C, send NACK
    rx = 8'h6C;
    bus.Read = 1'b1; bus.Ack_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      bit_step($sformatf("t2_b%0d", i), I2C_CMD_READ, 1'b0, 1'b0, rx[7-i]);
    bit_step("t2_ack", I2C_CMD_WRITE, 1'b1, 1'b1, 1'b0);
    check("t2_dout", 32'(bus.Dout), 32'h6C);
    check("t2_ackout", 32'(bus.Ack_out), 32'd0);
    finish_req("t2");
    bus.Ack_in = 1'b0;

    // 5: arbitration lost during bit 3 of a write, together with Bit_ack
    din = 8'h3C;
    bus.Write = 1'b1; bus.Din = din;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      bit_step($sformatf("t5_b%0d", i), I2C_CMD_WRITE, 1'b1, din[7-i], 1'b0);
    check("t5_b3_cmd", 32'(bus.Bit_cmd), 32'(I2C_CMD_WRITE));
    check("t5_b3_txd", 32'(bus.Bit_txd), 32'(din[4]));
    bus.Bit_ack = 1'b1; bus.Bit_al = 1'b1;
    @(negedge clk);
    bus.Bit_ack = 1'b0; bus.Bit_al = 1'b0; bus.Write = 1'b0;
    check("t5_al_cmd",    32'(bus.Bit_cmd), 32'(I2C_CMD_NOP));
    check("t5_al",        32'(bus.I2C_al),  32'd1);
    check("t5_al_cmdack", 32'(bus.Cmd_ack), 32'd0);
    check("t5_al_dout",   32'(bus.Dout),    32'h6C);
    @(negedge clk);
    check("t5_al_clr",   32'(bus.I2C_al),  32'd0);
    check("t5_idle_cmd", 32'(bus.Bit_cmd), 32'(I2C_CMD_NOP));
    check("t5_no_cmdack", 32'(bus.Cmd_ack), 32'd0);

    // 3: write 0x00 with STOP, slave NACKs
    bus.Write = 1'b1; bus.Stop = 1'b1; bus.Din = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      bit_step($sformatf("t3_b%0d", i), I2C_CMD_WRITE, 1'b1, 1'b0, 1'b0);
    bit_step("t3_ack", I2C_CMD_READ, 1'b0, 1'b0, 1'b1);
    check("t3_ackout", 32'(bus.Ack_out), 32'd1);
    bit_step("t3_stop", I2C_CMD_STOP, 1'b0, 1'b0, 1'b0);
    finish_req("t3");

    // 4: STOP alone, then START alone is ignored
    bus.Stop = 1'b1;
    @(negedge clk);
    bit_step("t4_stop", I2C_CMD_STOP, 1'b0, 1'b0, 1'b0);
    finish_req("t4");
    bus.Start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("t4_ign_cmd%0d", i), 32'(bus.Bit_cmd), 32'(I2C_CMD_NOP));
      check($sformatf("t4_ign_ack%0d", i), 32'(bus.Cmd_ack), 32'd0);
    end
    bus.Start = 1'b0;

    // 6: reset mid-read, then a fresh START + write 0x81
    bus.Read = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      bit_step($sformatf("t6_b%0d", i), I2C_CMD_READ, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_cmd",    32'(bus.Bit_cmd), 32'(I2C_CMD_NOP));
    check("t6_rst_txd",    32'(bus.Bit_txd), 32'd0);
    check("t6_rst_cmdack", 32'(bus.Cmd_ack), 32'd0);
    check("t6_rst_ackout", 32'(bus.Ack_out), 32'd0);
    check("t6_rst_dout",   32'(bus.Dout),    32'd0);
    check("t6_rst_al",     32'(bus.I2C_al),  32'd0);
    rst_n = 1'b1; bus.Read = 1'b0;
    @(negedge clk);
    check("t6_idle_cmd", 32'(bus.Bit_cmd), 32'(I2C_CMD_NOP));
    din = 8'h81;
    bus.Start = 1'b1; bus.Write = 1'b1; bus.Din = din;
    @(negedge clk);
    bit_step("t6_start", I2C_CMD_START, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      bit_step($sformatf("t6_w%0d", i), I2C_CMD_WRITE, 1'b1, din[7-i], 1'b0);
    bit_step("t6_ack", I2C_CMD_READ, 1'b0, 1'b0, 1'b0);
    check("t6_ackout", 32'(bus.Ack_out), 32'd0);
    finish_req("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
